// File: rtl/fcpu_pkg.sv
// Shared CRAM read-path types: address width, AXI response codes, burst encoding, R beat record.
// Pure declarations; no timing or backpressure of its own.
package fcpu_pkg;

   localparam int CRAM_ADDR_W = 12;
   localparam int ID_MAX_W    = 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2,
      BURST_RSVD  = 2'd3
   } burst_e;

   typedef struct packed {
      logic [ID_MAX_W-1:0] id;
      logic [31:0]         data;
      logic [1:0]          resp;
      logic                last;
   } r_beat_t;

   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/cram_rd_fifo.sv
// Two-entry R beat FIFO; push and pop take effect at the clock edge, head is registered.
// Caller never pushes when full or pops when empty; nrst flushes synchronously.
module cram_rd_fifo
   import fcpu_pkg::*;
(
   input  logic       clk,
   input  logic       nrst,
   input  logic       push,
   input  r_beat_t    push_dat,
   input  logic       pop,
   output r_beat_t    head,
   output logic [1:0] count
);

   r_beat_t    ent_q [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (nrst) begin
         ent_q[0] <= '0;
         ent_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push) begin
            ent_q[wr_ptr_q] <= push_dat;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign head  = ent_q[rd_ptr_q];
   assign count = cnt_q;

endmodule

// File: rtl/cram_axi_rd_slave.sv
// AXI4 read responder for the code RAM plus loader write port; first beat two cycles after AR.
// R backpressure stalls BRAM reads through a 2-entry FIFO, so no beat is dropped or repeated.
module cram_axi_rd_slave
   import fcpu_pkg::*;
#(
   parameter int ADDR_W = CRAM_ADDR_W,
   parameter int ID_W   = 4
)
(
   input  logic              clk,
   input  logic              nrst,
   input  logic [ID_W-1:0]   arid,
   input  logic [31:0]       araddr,
   input  logic [7:0]        arlen,
   input  logic [2:0]        arsize,
   input  logic [1:0]        arburst,
   input  logic              arvalid,
   output logic              arready,
   output logic [ID_W-1:0]   rid,
   output logic [31:0]       rdata,
   output logic [1:0]        rresp,
   output logic              rlast,
   output logic              rvalid,
   input  logic              rready,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [31:0]       ld_data
);

   localparam int AW    = ADDR_W - 2;
   localparam int DEPTH = 2 ** AW;

   typedef enum logic {ST_IDLE, ST_BURST} state_e;

   state_e          state_q, state_nx;
   logic [ID_W-1:0] id_q, id_nx;
   logic [AW-1:0]   waddr_q, waddr_nx;
   logic [AW-1:0]   wmask_q, wmask_nx;
   logic [7:0]      cnt_q, cnt_nx;
   burst_e          burst_q, burst_nx;
   logic            err_q, err_nx;
   logic            oob_q, oob_nx;
   logic            arready_q;

   logic            ar_fire;
   logic            req_err;
   logic            can_issue;
   logic            rd_en;

   logic            inf_vld_q;
   logic [ID_W-1:0] inf_id_q;
   logic            inf_zero_q;
   logic            inf_last_q;
   logic [31:0]     bram_q;
   logic [31:0]     mem [DEPTH];

   r_beat_t         inf_beat;
   r_beat_t         fifo_head;
   r_beat_t         out_beat;
   logic [1:0]      fifo_cnt;
   logic            fifo_empty;
   logic            fifo_push;
   logic            fifo_pop;
   logic            unused_ok;

   assign ar_fire = arvalid && arready_q;
   assign req_err = (arsize != 3'd2) || (arburst == 2'd3) ||
                    ((arburst == 2'd2) && !wrap_len_ok(arlen)) ||
                    ((araddr >> ADDR_W) != 32'd0);
   // A beat in the BRAM stage always lands somewhere next cycle, so it counts as occupancy.
   assign can_issue = ({1'b0, fifo_cnt} + {2'b00, inf_vld_q}) < 3'd2;

   always_comb begin
      state_nx = state_q;
      id_nx    = id_q;
      waddr_nx = waddr_q;
      wmask_nx = wmask_q;
      cnt_nx   = cnt_q;
      burst_nx = burst_q;
      err_nx   = err_q;
      oob_nx   = oob_q;
      rd_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ar_fire) begin
               id_nx    = arid;
               waddr_nx = araddr[ADDR_W-1:2];
               wmask_nx = AW'(arlen);
               cnt_nx   = arlen;
               burst_nx = burst_e'(arburst);
               err_nx   = req_err;
               oob_nx   = 1'b0;
               state_nx = ST_BURST;
            end
         end
         ST_BURST: begin
            if (can_issue) begin
               rd_en = 1'b1;
               if (cnt_q == 8'd0) begin
                  state_nx = ST_IDLE;
               end else begin
                  cnt_nx = cnt_q - 8'd1;
                  case (burst_q)
                     BURST_INCR: begin
                        waddr_nx = waddr_q + AW'(1);
                        // Stepping past the top word makes every later beat of this burst an error.
                        if (waddr_q == {AW{1'b1}}) oob_nx = 1'b1;
                     end
                     BURST_WRAP: begin
                        waddr_nx = (waddr_q & ~wmask_q) | ((waddr_q + AW'(1)) & wmask_q);
                     end
                     default: waddr_nx = waddr_q;
                  endcase
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         state_q   <= ST_IDLE;
         id_q      <= '0;
         waddr_q   <= '0;
         wmask_q   <= '0;
         cnt_q     <= 8'd0;
         burst_q   <= BURST_FIXED;
         err_q     <= 1'b0;
         oob_q     <= 1'b0;
         arready_q <= 1'b0;
      end else begin
         state_q   <= state_nx;
         id_q      <= id_nx;
         waddr_q   <= waddr_nx;
         wmask_q   <= wmask_nx;
         cnt_q     <= cnt_nx;
         burst_q   <= burst_nx;
         err_q     <= err_nx;
         oob_q     <= oob_nx;
         arready_q <= (state_nx == ST_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (ld_we) mem[ld_addr[ADDR_W-1:2]] <= ld_data;
   end

   // Separate process from the write so a same-word read sees the pre-write contents.
   always_ff @(posedge clk) begin
      if (nrst) begin
         inf_vld_q  <= 1'b0;
         inf_id_q   <= '0;
         inf_zero_q <= 1'b0;
         inf_last_q <= 1'b0;
         bram_q     <= 32'd0;
      end else begin
         inf_vld_q <= rd_en;
         if (rd_en) begin
            inf_id_q   <= id_q;
            inf_zero_q <= err_q || oob_q;
            inf_last_q <= (cnt_q == 8'd0);
            bram_q     <= mem[waddr_q];
         end
      end
   end

   always_comb begin
      inf_beat      = '0;
      inf_beat.id   = ID_MAX_W'(inf_id_q);
      inf_beat.data = inf_zero_q ? 32'd0 : bram_q;
      inf_beat.resp = inf_zero_q ? RESP_SLVERR : RESP_OKAY;
      inf_beat.last = inf_last_q;
   end

   assign fifo_empty = (fifo_cnt == 2'd0);
   assign fifo_push  = inf_vld_q && !(fifo_empty && rready);
   assign fifo_pop   = rready && !fifo_empty;

   cram_rd_fifo u_fifo (
      .clk      (clk),
      .nrst     (nrst),
      .push     (fifo_push),
      .push_dat (inf_beat),
      .pop      (fifo_pop),
      .head     (fifo_head),
      .count    (fifo_cnt)
   );

   // With the FIFO empty the BRAM stage is presented directly; both sources are registers.
   assign out_beat = fifo_empty ? inf_beat : fifo_head;
   assign rvalid   = !fifo_empty || inf_vld_q;
   assign rid      = out_beat.id[ID_W-1:0];
   assign rdata    = out_beat.data;
   assign rresp    = out_beat.resp;
   assign rlast    = out_beat.last;
   assign arready  = arready_q;

   assign unused_ok = ^{araddr[1:0], ld_addr[1:0], out_beat.id};

endmodule

// File: doc/cram_axi_rd_slave.md
# cram_axi_rd_slave

AXI4 read-only responder that serves the code RAM (CRAM) to the instruction-fetch master, plus a simple write port the program loader uses to fill it. It accepts one AR burst at a time, reads a synchronous single-port-read BRAM, and returns beats through a 2-entry output FIFO so R backpressure never drops data. Sits between the fetch scheduler's `s_cram_*` read ports and the CRAM storage.

## Interface
Parameters:
- ADDR_W, default CRAM_ADDR_W: byte-address width of CRAM; depth = 2**(ADDR_W-2) 32-bit words.
- ID_W, default 4: AXI ID width.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-high
- arid  in  ID_W  read ID
- araddr  in  32  byte address
- arlen  in  8  beats-1
- arsize  in  3  must be 3'd2
- arburst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rid  out  ID_W  ID of beat
- rdata  out  32  read data
- rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- rlast  out  1  last beat of burst
- rvalid  out  1  R valid
- rready  in  1  R ready
- ld_we  in  1  loader write enable
- ld_addr  in  ADDR_W  loader byte address (bits [1:0] ignored)
- ld_data  in  32  loader write data

## Operation
- FSM IDLE / BURST. IDLE: arready=1. AR handshake latches id, word address (araddr[ADDR_W-1:2]), beat counter = arlen, burst type, error flag; go BURST.
- Request-level error (SLVERR on every beat, rdata=0): arsize != 2; arburst == 3; WRAP with arlen not in {1,3,7,15}; araddr[31:ADDR_W] != 0.
- BURST: issue one BRAM read per cycle when FIFO occupancy + reads in flight < 2. Per-beat address update: FIXED unchanged; INCR +1 word; WRAP +1 word within aligned block of (arlen+1) words, wrapping to block base.
- INCR crossing end of memory: beats with word index ≥ depth return SLVERR, rdata=0; remaining beats still returned. Exactly arlen+1 beats always returned.
- Issuing beat with counter 0 tags it last and returns FSM to IDLE next cycle; next AR may be accepted while prior beats drain. Each FIFO entry carries its own id/resp/last.
- Loader write and read to same word in same cycle: read returns old data (read-first). Writes never blocked; writes with ld_addr beyond depth impossible by width.
- Reset: arready=0, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0; FIFO and in-flight read flushed, FSM IDLE. Mid-burst reset abandons burst silently. CRAM contents not cleared. arready=1 first cycle after nrst deasserts.

## Timing
- AR handshake in cycle T → first rvalid in cycle T+2 (BRAM read issued T+1, registered).
- rready held 1: one beat per cycle, burst of N beats completes by T+N+1; next AR accepted at earliest one cycle after last read issued.
- rvalid, rdata, rid, rresp, rlast held stable while rvalid && !rready.
- arready registered state only, no combinational path from arvalid; no combinational path rready → any R output.
- FIFO full and rready=0: reads stall, counter frozen, no beat lost or duplicated.

## Structure
- fcpu_pkg: CRAM_ADDR_W, RESP_OKAY/RESP_SLVERR constants, burst enum (BURST_FIXED/INCR/WRAP), typedef r_beat_t {id, data, resp, last}.
- Sub-module cram_rd_fifo: 2-entry r_beat_t FIFO, push/pop/count, synchronous flush on nrst.
- BRAM array inferred in top level.

## Test plan
- Load words 0..15 with 0x1000+i; AR araddr=0x0, arlen=3, INCR, rready=1 → rdata 0x1000..0x1003 at T+2..T+5, rlast only on 4th, rresp=0, rid=arid.
- Same burst, rready toggling 1-0-0-1 → same 4 beats, in order, R outputs stable while stalled, no loss.
- WRAP araddr=0x18, arlen=3 → words 6,7,4,5 (0x1006,0x1007,0x1004,0x1005).
- arsize=3 arlen=1 → 2 beats rresp=2'b10 rdata=0; araddr at last word, INCR arlen=1 → beat1 OKAY, beat2 SLVERR.
- Back-to-back ARs id 1 then 2, arlen=0 → second arready within 2 cycles, beats return in order with rid 1 then 2.
- nrst asserted mid 8-beat burst → next cycle rvalid=0, arready=0; after release, new arlen=0 read returns correct data, no stale beats.
